// File: rtl/matrix_op_scheduler_if.sv
// Request, engine and response signal bundle for matrix_op_scheduler.
// The scheduler uses the slave modport; requesters, engine and consumer use master.
interface matrix_op_scheduler_if #(
  parameter int MATRIX_W = 256,
  parameter int OP_W     = 4
);
  logic                req0_valid;
  logic                req0_ready;
  logic [OP_W-1:0]     req0_op;
  logic [MATRIX_W-1:0] req0_a;
  logic [MATRIX_W-1:0] req0_b;
  logic                req1_valid;
  logic                req1_ready;
  logic [OP_W-1:0]     req1_op;
  logic [MATRIX_W-1:0] req1_a;
  logic [MATRIX_W-1:0] req1_b;
  logic                eng_enable;
  logic [OP_W-1:0]     eng_op;
  logic [MATRIX_W-1:0] eng_a;
  logic [MATRIX_W-1:0] eng_b;
  logic [MATRIX_W-1:0] eng_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic                rsp_err;
  logic [MATRIX_W-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  eng_result, rsp_ready,
    output req0_ready, req1_ready,
    output eng_enable, eng_op, eng_a, eng_b,
    output rsp_valid, rsp_id, rsp_err, rsp_data
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output eng_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  eng_enable, eng_op, eng_a, eng_b,
    input  rsp_valid, rsp_id, rsp_err, rsp_data
  );
endinterface

// File: rtl/matrix_op_scheduler.sv
// Two-requester arbiter in front of a shared matrix engine.
// Define MATRIX_SCHED_FIXED_PRIO_EN for fixed req0 priority instead of round-robin.
module matrix_op_scheduler #(
  parameter int MATRIX_W = 256,
  parameter int OP_W     = 4,
  parameter int NUM_OPS  = 5,
  parameter int LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_op_scheduler_if.slave  bus
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic [OP_W-1:0]     eng_op_q, eng_op_d;
  logic [MATRIX_W-1:0] eng_a_q, eng_a_d;
  logic [MATRIX_W-1:0] eng_b_q, eng_b_d;
  logic                rsp_id_q, rsp_id_d;
  logic                rsp_err_q, rsp_err_d;
  logic [MATRIX_W-1:0] rsp_data_q, rsp_data_d;

  logic                grant_any;
  logic                grant_id;
  logic [OP_W-1:0]     sel_op;
  logic [MATRIX_W-1:0] sel_a;
  logic [MATRIX_W-1:0] sel_b;
  logic                sel_illegal;

  // Ready is gated by reset so a handshake can never be dropped silently.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any = 1'b1;
`ifdef MATRIX_SCHED_FIXED_PRIO_EN
        grant_id  = 1'b0;
`else
        grant_id  = ~last_grant_q;
`endif
      end else if (bus.req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign sel_op      = grant_id ? bus.req1_op : bus.req0_op;
  assign sel_a       = grant_id ? bus.req1_a  : bus.req0_a;
  assign sel_b       = grant_id ? bus.req1_b  : bus.req0_b;
  assign sel_illegal = (32'(sel_op) >= 32'(NUM_OPS));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    eng_op_d     = eng_op_q;
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          eng_op_d     = sel_op;
          eng_a_d      = sel_a;
          eng_b_d      = sel_b;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          cnt_d        = '0;
          if (sel_illegal) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = RESP;
          end else begin
            state_d    = EXEC;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          rsp_data_d = bus.eng_result;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      eng_op_q     <= '0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      eng_op_q     <= eng_op_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.req0_ready = grant_any & ~grant_id;
  assign bus.req1_ready = grant_any & grant_id;
  assign bus.eng_enable = (state_q == EXEC);
  assign bus.eng_op     = eng_op_q;
  assign bus.eng_a      = eng_a_q;
  assign bus.eng_b      = eng_b_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Directed bench for matrix_op_scheduler with a behavioural matrix engine
// (op 0 transpose, 1 add, 2 multiply, 3 subtract, 4 pass A).
module tb_matrix_op_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;

  matrix_op_scheduler_if #(.MATRIX_W(256), .OP_W(4)) bus ();

  matrix_op_scheduler #(
    .MATRIX_W(256),
    .OP_W(4),
    .NUM_OPS(5),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] row(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  function automatic logic [255:0] eng_model(input logic [3:0] op, input logic [255:0] a,
                                             input logic [255:0] b);
    logic [255:0] r;
    logic [15:0]  acc;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        case (op)
          4'd0: r[j*16+i*64 +: 16] = a[i*16+j*64 +: 16];
          4'd1: r[j*16+i*64 +: 16] = a[j*16+i*64 +: 16] + b[j*16+i*64 +: 16];
          4'd2: begin
            acc = '0;
            for (int k = 0; k < 4; k++)
              acc = acc + 16'(a[k*16+i*64 +: 16] * b[j*16+k*64 +: 16]);
            r[j*16+i*64 +: 16] = acc;
          end
          4'd3: r[j*16+i*64 +: 16] = a[j*16+i*64 +: 16] - b[j*16+i*64 +: 16];
          default: r[j*16+i*64 +: 16] = a[j*16+i*64 +: 16];
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] gen(input int n, input int k);
    logic [255:0] m;
    for (int j = 0; j < 16; j++) m[j*16 +: 16] = 16'(n*1000 + k*16 + j + 1);
    return m;
  endfunction

  always_comb begin
    bus.eng_result = '0;
    if (bus.eng_enable) bus.eng_result = eng_model(bus.eng_op, bus.eng_a, bus.eng_b);
  end

  // Handshake monitors; sampled at negedge where all inputs are settled.
  int           acc_id_q[$];
  int           acc_cyc_q[$];
  int           rsp_id_q[$];
  logic         rsp_err_q[$];
  logic [255:0] rsp_data_q[$];

  always @(negedge clk) begin
    if (!reset && bus.req0_valid && bus.req0_ready) begin
      acc_id_q.push_back(0); acc_cyc_q.push_back(cyc);
    end
    if (!reset && bus.req1_valid && bus.req1_ready) begin
      acc_id_q.push_back(1); acc_cyc_q.push_back(cyc);
    end
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      rsp_id_q.push_back(int'(bus.rsp_id));
      rsp_err_q.push_back(bus.rsp_err);
      rsp_data_q.push_back(bus.rsp_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_id_q.delete(); acc_cyc_q.delete();
    rsp_id_q.delete(); rsp_err_q.delete(); rsp_data_q.delete();
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] flags;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    reset = 1'b1;
    step(); step();
    #1;
    flags = {bus.eng_enable, bus.rsp_valid, bus.req0_ready, bus.req1_ready};
    vec_cnt++;
    if (flags !== 4'b0000) begin
      err_cnt++; $display("FAIL reset_flags: got %b expected 0000", flags);
    end
    vec_cnt++;
    if ({bus.eng_op, bus.eng_a, bus.eng_b, bus.rsp_id, bus.rsp_err, bus.rsp_data} !== '0) begin
      err_cnt++; $display("FAIL reset_regs: got op=%h id=%b err=%b, expected all zero",
                          bus.eng_op, bus.rsp_id, bus.rsp_err);
    end
    idle_inputs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_transpose();
    logic [255:0] a, exp_d;
    a     = {row(8,5,7,6), row(6,5,4,3), row(7,3,8,4), row(5,8,9,2)};
    exp_d = {row(2,4,3,6), row(9,8,4,7), row(8,3,5,5), row(5,7,6,8)};
    bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = a; bus.req0_b = '0;
    #1;
    vec_cnt++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      err_cnt++; $display("FAIL tr_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    step();
    bus.req0_valid = 1'b0;
    vec_cnt++;
    if ({bus.eng_enable, bus.rsp_valid, bus.eng_op, bus.eng_a} !== {2'b10, 4'd0, a}) begin
      err_cnt++; $display("FAIL tr_exec1: got en=%b vld=%b op=%h expected en=1 vld=0 op=0",
                          bus.eng_enable, bus.rsp_valid, bus.eng_op);
    end
    step();
    vec_cnt++;
    if ({bus.eng_enable, bus.rsp_valid} !== 2'b10) begin
      err_cnt++; $display("FAIL tr_exec2: got en=%b vld=%b expected en=1 vld=0",
                          bus.eng_enable, bus.rsp_valid);
    end
    step();
    vec_cnt++;
    if ({bus.eng_enable, bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== 4'b0100) begin
      err_cnt++; $display("FAIL tr_resp: got en=%b vld=%b id=%b err=%b expected 0 1 0 0",
                          bus.eng_enable, bus.rsp_valid, bus.rsp_id, bus.rsp_err);
    end
    vec_cnt++;
    if (bus.rsp_data !== exp_d) begin
      err_cnt++; $display("FAIL tr_data: got %h expected %h", bus.rsp_data, exp_d);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    vec_cnt++;
    if (bus.rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL tr_done: rsp_valid got %b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_illegal();
    bus.req1_valid = 1'b1; bus.req1_op = 4'd7; bus.req1_a = gen(3, 1); bus.req1_b = gen(4, 1);
    #1;
    vec_cnt++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      err_cnt++; $display("FAIL il_ready: got %b expected 01", {bus.req0_ready, bus.req1_ready});
    end
    step();
    bus.req1_valid = 1'b0;
    vec_cnt++;
    if ({bus.eng_enable, bus.rsp_valid, bus.rsp_err, bus.rsp_id} !== 4'b0111) begin
      err_cnt++; $display("FAIL il_resp: got en=%b vld=%b err=%b id=%b expected 0 1 1 1",
                          bus.eng_enable, bus.rsp_valid, bus.rsp_err, bus.rsp_id);
    end
    vec_cnt++;
    if (bus.rsp_data !== '0) begin
      err_cnt++; $display("FAIL il_data: got %h expected 0", bus.rsp_data);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    vec_cnt++;
    if ({bus.eng_enable, bus.rsp_valid} !== 2'b00) begin
      err_cnt++; $display("FAIL il_after: got en=%b vld=%b expected 0 0",
                          bus.eng_enable, bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] a, exp_d;
    a     = {row(13,14,15,16), row(9,10,11,12), row(5,6,7,8), row(1,2,3,4)};
    exp_d = {row(113,114,115,116), row(109,110,111,112), row(105,106,107,108), row(101,102,103,104)};
    clear_mon();
    bus.req0_valid = 1'b1; bus.req0_op = 4'd1; bus.req0_a = a; bus.req0_b = {16{16'd100}};
    step();
    bus.req0_op = 4'd3; bus.req0_a = gen(0, 9);
    bus.req1_valid = 1'b1; bus.req1_op = 4'd4; bus.req1_a = gen(1, 9);
    step(); step();
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if ({bus.rsp_valid, bus.rsp_id, bus.req0_ready, bus.req1_ready} !== 4'b1000 ||
          bus.rsp_data !== exp_d) begin
        err_cnt++; $display("FAIL bp_hold%0d: got vld=%b id=%b rdy=%b%b data=%h expected 1 0 00 %h",
                            i, bus.rsp_valid, bus.rsp_id, bus.req0_ready, bus.req1_ready,
                            bus.rsp_data, exp_d);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    vec_cnt++;
    if (rsp_id_q.size() !== 1 || bus.rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL bp_release: got %0d handshakes vld=%b expected 1 and 0",
                          rsp_id_q.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    clear_mon();
    bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = gen(2, 5); bus.req0_b = gen(2, 6);
    step();
    bus.req0_valid = 1'b0;
    step();
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    vec_cnt++;
    if ({bus.eng_enable, bus.rsp_valid, bus.eng_op, bus.eng_a, bus.eng_b,
         bus.rsp_id, bus.rsp_err, bus.rsp_data} !== '0) begin
      err_cnt++; $display("FAIL rm_outputs: got en=%b vld=%b op=%h, expected all zero",
                          bus.eng_enable, bus.rsp_valid, bus.eng_op);
    end
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      err_cnt++; $display("FAIL rm_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step(); step(); step();
    bus.rsp_ready = 1'b0;
    vec_cnt++;
    if (rsp_id_q.size() !== 0 || bus.rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL rm_norsp: got %0d responses vld=%b expected 0 and 0",
                          rsp_id_q.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_contention();
    int exp_order[8];
    int k0, k1, e0, e1;
    logic g0, g1;
    logic [255:0] exp_d;
`ifdef MATRIX_SCHED_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_mon();
    k0 = 0; k1 = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 200 && (k0 < 4 || k1 < 4); c++) begin
      bus.req0_valid = (k0 < 4); bus.req0_op = 4'd1; bus.req0_a = gen(0, k0); bus.req0_b = gen(2, k0);
      bus.req1_valid = (k1 < 4); bus.req1_op = 4'd2; bus.req1_a = gen(1, k1); bus.req1_b = gen(3, k1);
      #1;
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      step();
      if (g0) k0++;
      if (g1) k1++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int c = 0; c < 20 && rsp_id_q.size() < 8; c++) step();
    bus.rsp_ready = 1'b0;
    vec_cnt++;
    if (rsp_id_q.size() !== 8) begin
      err_cnt++; $display("FAIL ct_count: got %0d responses expected 8", rsp_id_q.size());
    end else begin
      e0 = 0; e1 = 0;
      for (int i = 0; i < 8; i++) begin
        if (exp_order[i] == 0) begin exp_d = eng_model(4'd1, gen(0, e0), gen(2, e0)); e0++; end
        else begin exp_d = eng_model(4'd2, gen(1, e1), gen(3, e1)); e1++; end
        vec_cnt++;
        if (rsp_id_q[i] !== exp_order[i] || rsp_data_q[i] !== exp_d || rsp_err_q[i] !== 1'b0) begin
          err_cnt++; $display("FAIL ct_rsp%0d: got id=%0d err=%b data=%h expected id=%0d err=0 data=%h",
                              i, rsp_id_q[i], rsp_err_q[i], rsp_data_q[i], exp_order[i], exp_d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k0;
    logic g0;
    logic [255:0] exp_d;
    clear_mon();
    k0 = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 100 && k0 < 3; c++) begin
      bus.req0_valid = 1'b1; bus.req0_op = 4'(k0 * 2); bus.req0_a = gen(5, k0); bus.req0_b = gen(6, k0);
      #1;
      g0 = bus.req0_ready;
      step();
      if (g0) k0++;
    end
    bus.req0_valid = 1'b0;
    for (int c = 0; c < 20 && rsp_id_q.size() < 3; c++) step();
    bus.rsp_ready = 1'b0;
    vec_cnt++;
    if (acc_cyc_q.size() !== 3 || rsp_id_q.size() !== 3) begin
      err_cnt++; $display("FAIL b2b_count: got %0d accepts %0d responses expected 3 and 3",
                          acc_cyc_q.size(), rsp_id_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vec_cnt++;
        if (acc_cyc_q[i] - acc_cyc_q[i-1] !== 4) begin
          err_cnt++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 4",
                              i, acc_cyc_q[i] - acc_cyc_q[i-1]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        exp_d = eng_model(4'(i * 2), gen(5, i), gen(6, i));
        vec_cnt++;
        if (rsp_id_q[i] !== 0 || rsp_data_q[i] !== exp_d) begin
          err_cnt++; $display("FAIL b2b_rsp%0d: got id=%0d data=%h expected id=0 data=%h",
                              i, rsp_id_q[i], rsp_data_q[i], exp_d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_transpose();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_contention();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/matrix_op_scheduler.md
Name: matrix_op_scheduler

Overview:
Shares one matrix math engine (transpose/add/multiply datapath, 4x4 x 16-bit matrices packed in 256 bits) between two requesters. Arbitrates requests, latches operands and opcode, and holds the engine enable for a fixed latency. It then captures the 256-bit result and returns it with a valid/ready response tagged by requester ID. Sits between the CPU execute stage / secondary requester and the math modules.

Parameters:
MATRIX_W, 256, packed matrix width; element [row][col] occupies bits (col*16 + row*64)+15 -: 16
OP_W, 4, opcode width
NUM_OPS, 5, opcodes 0..NUM_OPS-1 legal; others illegal
LATENCY, 2, engine cycles with enable high before result is sampled (>=1)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_op  in  OP_W  opcode
req0_a  in  MATRIX_W  operand A
req0_b  in  MATRIX_W  operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
eng_enable  out  1  engine enable
eng_op  out  OP_W  opcode to engine
eng_a  out  MATRIX_W  operand A to engine
eng_b  out  MATRIX_W  operand B to engine
eng_result  in  MATRIX_W  engine output
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_err  out  1  illegal opcode
rsp_data  out  MATRIX_W  result matrix

Behaviour:
- Reset (sync, active-high): state=IDLE, cnt=0, last_grant=1, all outputs 0 (eng_*, rsp_*, req*_ready). Reset mid-operation drops the in-flight op; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE: reqN_ready is combinational, asserted only for the granted requester, only in IDLE. Handshake completes when valid&&ready.
  - Grant rules: only one valid → that one. Both valid → the one != last_grant (round-robin).
  - On accept: latch op/a/b into eng_op/eng_a/eng_b, set rsp_id=grant, last_grant=grant, cnt=0.
  - Legal op → EXEC. Illegal op (>=NUM_OPS) → RESP with rsp_err=1, rsp_data=0; engine never enabled.
- EXEC: eng_enable=1; eng_op/eng_a/eng_b stable. cnt increments each cycle. On the edge where cnt==LATENCY-1: rsp_data<=eng_result, rsp_err<=0, go RESP.
  - eng_enable is high for exactly LATENCY cycles.
- RESP: rsp_valid=1, eng_enable=0. rsp_data/rsp_id/rsp_err held stable until rsp_valid&&rsp_ready, then → IDLE. Backpressure of any length is allowed.
- Timing:
  - rsp_valid rises LATENCY cycles after the accept edge.
  - Illegal op: rsp_valid rises 1 cycle after the accept edge.
  - Next accept is no earlier than the cycle after response handshake; legal-op throughput is one op per LATENCY+2 cycles minimum.
- Outside EXEC, eng_op/eng_a/eng_b hold their last value.
- Requests arriving outside IDLE see ready=0 and must be held by the requester; no request is lost or duplicated.
- No width change: eng_result passes to rsp_data unmodified.

Optional Feature:
MATRIX_SCHED_FIXED_PRIO_EN
- Defined: fixed priority; req0 always wins when both are valid; last_grant is still updated but ignored.
- Undefined (default): round-robin as in Behaviour.

Test Plan:
- Basic transpose: req0 op=0, a=[[5,8,9,2],[7,3,8,4],[6,5,4,3],[8,5,7,6]]; bench engine model transposes.
  → eng_enable high exactly 2 cycles; rsp_valid 2 cycles after accept; rsp_id=0; rsp_err=0; rsp_data rows [5,7,6,8],[8,3,5,5],[9,8,4,7],[2,4,3,6].
- Contention: req0 and req1 both valid continuously, 4 ops each, rsp_ready=1.
  → grants alternate 0,1,0,1... starting with 0. With MATRIX_SCHED_FIXED_PRIO_EN: all four req0 ops complete before the first req1 grant.
- Backpressure: rsp_ready=0 for 10 cycles during RESP.
  → rsp_valid/rsp_data/rsp_id stable all 10 cycles; req0_ready/req1_ready stay 0; single handshake on the cycle rsp_ready rises.
- Illegal op: req1 op=7.
  → eng_enable never asserts; rsp_valid 1 cycle after accept; rsp_err=1, rsp_id=1, rsp_data=0.
- Reset mid-op: assert reset for 1 cycle during the second EXEC cycle.
  → next cycle all outputs 0, state IDLE, no rsp_valid; the following request is granted to req0 (last_grant=1).
- Back-to-back same requester: req0 valid with 3 ops, req1 idle.
  → 3 responses in order, each accept spaced LATENCY+2 = 4 cycles.
